ws2812b_capture_sequencer: RTL and testbench
============================================

Name: ws2812b_capture_sequencer

Overview:
- Frame-level controller for the WS2812b impostor receive path. It sits after the byte assembler and idle detector, and before the demux and host register file.
- Counts pixels within a frame and selects which pixel index the impostor captures. The default is index 0, which gives normal WS2812b behaviour.
- Drives the demux consume/forward decision, commits the captured GRB triple to host-visible registers at frame end, and manages the ready/overrun handshake with TinyQV.

Parameters:
PIX_W, 8, width of pixel index, target index and pixel counters.

Ports:
clk  in  1  system clock (64 MHz nominal)
reset  in  1  synchronous, active-high reset
byte_valid  in  1  one-cycle strobe: byte_data holds a completed byte
byte_data  in  8  assembled byte, MSB first on wire
idle  in  1  level: line idle (latch/reset gap) detected
cfg_target  in  PIX_W  pixel index to capture; host register, may change any time
host_clear  in  1  one-cycle strobe: host acknowledges ready
consume  out  1  high while incoming bits belong to the captured pixel; demux suppresses dout
rgb_g  out  8  committed green
rgb_r  out  8  committed red
rgb_b  out  8  committed blue
rgb_ready  out  1  sticky: new triple committed since last host_clear
overrun  out  1  sticky: commit occurred while rgb_ready already set; cleared by host_clear
frame_pixels  out  PIX_W  complete pixels seen in last committed or aborted frame, saturating
short_frame  out  1  one-cycle pulse: frame ended before target pixel completed

Behaviour:
Reset:
- Applies on any cycle, including mid-frame.
- state=ARMED, all counters and staging cleared.
- rgb_g/r/b=0, rgb_ready=0, overrun=0, frame_pixels=0, short_frame=0.
- active_target=cfg_target on the cycle after reset.

Internal state:
- byte_in_pix (0..2).
- pix_idx (PIX_W bits, saturates at all-ones, never wraps).
- active_target.
- staging stg_g/stg_r/stg_b.
- captured flag.

State machine, states ARMED, SKIP, CAPTURE, PASS:
- ARMED: active_target<=cfg_target every cycle; counters held at 0.
  - byte_valid && !idle: next state is CAPTURE if active_target==0, else SKIP. The byte is processed as in the target state.
- SKIP: each byte_valid increments byte_in_pix. On the 3rd byte, byte_in_pix<=0 and pix_idx++. When pix_idx+1==active_target, go to CAPTURE.
- CAPTURE: bytes 0,1,2 go to stg_g, stg_r, stg_b respectively. On the 3rd byte, set captured=1, pix_idx++, and go to PASS.
- PASS: count bytes and pixels as in SKIP; no data is stored.
- cfg_target is frozen (via active_target) for the whole frame outside ARMED.

consume (combinational):
- consume = !idle && (state==CAPTURE || (state==ARMED && cfg_target==0)).
- It must be valid before the first bit of the target pixel arrives.

Frame end: idle high while state!=ARMED, evaluated next cycle.
- state<=ARMED and counters cleared.
- frame_pixels<=pix_idx, where pix_idx already counts completed pixels.
- If captured=1:
  - rgb_*<=stg_* and rgb_ready<=1.
  - overrun<=1 if rgb_ready was already 1 and host_clear is not asserted this cycle.
- If captured=0: short_frame pulses for 1 cycle and outputs are unchanged.
- A partial pixel (byte_in_pix!=0) is discarded.

Idle behaviour:
- idle high in ARMED: no effect.
- byte_valid while idle is high is ignored.
- byte_valid and idle in the same cycle: idle wins.

Host handshake:
- host_clear clears rgb_ready and overrun.
- If host_clear and a commit occur in the same cycle, the commit wins: rgb_ready=1, overrun=0.

Latency:
- byte_valid at cycle t: staging/state updated at t+1.
- idle asserted at t (state!=ARMED): rgb_*, rgb_ready and frame_pixels visible at t+1.

Saturation: pix_idx saturates at 2^PIX_W-1. A target equal to the saturated value is never captured; the frame reports short_frame.

Decomposition:
- Shared package ws2812b_pkg holds:
  - state enum SEQ_ARMED/SEQ_SKIP/SEQ_CAPTURE/SEQ_PASS;
  - BYTES_PER_PIXEL=3;
  - byte-slot constants SLOT_G=0, SLOT_R=1, SLOT_B=2.
- One natural sub-module, ws2812b_pixel_counter: byte_in_pix/pix_idx counting with saturation, pixel_done strobe and clear input.
- The FSM, staging and handshake stay in the top.

Test Plan:
1. cfg_target=0; send frame GRB=12,34,56 then 9,9,9; idle.
   - consume high for the first 24 bits only.
   - Next cycle: rgb_g=0x12, rgb_r=0x34, rgb_b=0x56; rgb_ready=1; frame_pixels=2.
2. cfg_target=2; send 4 pixels with pixel2=AA,BB,CC; idle.
   - rgb_g/r/b=AA/BB/CC; consume high only during pixel2 bytes.
3. cfg_target=5; send 3 pixels; idle.
   - short_frame pulse; rgb_* unchanged; rgb_ready stays 0; frame_pixels=3.
4. Two committed frames without host_clear.
   - overrun=1 after the second commit.
   - host_clear in the same cycle as a third commit: rgb_ready=1, overrun=0.
5. Change cfg_target 0→1 mid-frame.
   - The current frame still captures pixel0; the next frame captures pixel1.
6. Assert reset after 4 bytes of a frame.
   - All outputs 0, state ARMED.
   - A following full frame captures correctly.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812b impostor frame sequencer.
// Byte slots follow the GRB order of WS2812b pixels on the wire.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        SEQ_ARMED   = 2'd0,
        SEQ_SKIP    = 2'd1,
        SEQ_CAPTURE = 2'd2,
        SEQ_PASS    = 2'd3
    } seq_state_e;

    localparam int BYTES_PER_PIXEL = 3;

    localparam logic [1:0] SLOT_G = 2'd0;
    localparam logic [1:0] SLOT_R = 2'd1;
    localparam logic [1:0] SLOT_B = 2'd2;

endpackage

// File: rtl/ws2812b_pixel_counter.sv
// Byte-within-pixel and pixel-index counting for one frame.
// pix_idx holds completed pixels and saturates instead of wrapping.
module ws2812b_pixel_counter
    import ws2812b_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_en,
    output logic [1:0]       byte_in_pix,
    output logic [PIX_W-1:0] pix_idx,
    output logic             pixel_done
);

    localparam logic [1:0]       LAST_SLOT = 2'(BYTES_PER_PIXEL - 1);
    localparam logic [PIX_W-1:0] PIX_MAX   = '1;

    logic [1:0]       byte_in_pix_d, byte_in_pix_q;
    logic [PIX_W-1:0] pix_idx_d, pix_idx_q;

    always_comb begin
        byte_in_pix_d = byte_in_pix_q;
        pix_idx_d     = pix_idx_q;
        pixel_done    = byte_en && (byte_in_pix_q == LAST_SLOT);
        if (clear) begin
            byte_in_pix_d = '0;
            pix_idx_d     = '0;
        end else if (byte_en) begin
            if (pixel_done) begin
                byte_in_pix_d = '0;
                if (pix_idx_q != PIX_MAX) begin
                    pix_idx_d = pix_idx_q + 1'b1;
                end
            end else begin
                byte_in_pix_d = byte_in_pix_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_in_pix_q <= '0;
            pix_idx_q     <= '0;
        end else begin
            byte_in_pix_q <= byte_in_pix_d;
            pix_idx_q     <= pix_idx_d;
        end
    end

    assign byte_in_pix = byte_in_pix_q;
    assign pix_idx     = pix_idx_q;

endmodule

// File: rtl/ws2812b_capture_sequencer.sv
// Frame-level sequencer: picks the captured pixel, drives the demux consume
// decision and commits the captured GRB triple to host registers at frame end.
module ws2812b_capture_sequencer
    import ws2812b_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             idle,
    input  logic [PIX_W-1:0] cfg_target,
    input  logic             host_clear,
    output logic             consume,
    output logic [7:0]       rgb_g,
    output logic [7:0]       rgb_r,
    output logic [7:0]       rgb_b,
    output logic             rgb_ready,
    output logic             overrun,
    output logic [PIX_W-1:0] frame_pixels,
    output logic             short_frame
);

    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    seq_state_e       state_d, state_q, proc_state;
    logic [PIX_W-1:0] active_target_d, active_target_q;
    logic [7:0]       stg_g_d, stg_g_q, stg_r_d, stg_r_q, stg_b_d, stg_b_q;
    logic             captured_d, captured_q;
    logic [7:0]       rgb_g_d, rgb_g_q, rgb_r_d, rgb_r_q, rgb_b_d, rgb_b_q;
    logic             rgb_ready_d, rgb_ready_q;
    logic             overrun_d, overrun_q;
    logic [PIX_W-1:0] frame_pixels_d, frame_pixels_q;
    logic             short_frame_d, short_frame_q;

    logic             byte_en, frame_end, pixel_done, target_hit;
    logic [1:0]       byte_in_pix;
    logic [PIX_W-1:0] pix_idx;

    // Idle wins over a coincident byte strobe.
    assign byte_en   = byte_valid && !idle;
    assign frame_end = idle && (state_q != SEQ_ARMED);

    ws2812b_pixel_counter #(.PIX_W(PIX_W)) u_pixel_counter (
        .clk         (clk),
        .reset       (reset),
        .clear       (frame_end),
        .byte_en     (byte_en),
        .byte_in_pix (byte_in_pix),
        .pix_idx     (pix_idx),
        .pixel_done  (pixel_done)
    );

    // A target at the saturated index can never be reached.
    assign target_hit = ({1'b0, pix_idx} + 1'b1 == {1'b0, active_target_q})
                        && (active_target_q != PIX_MAX);

    assign consume = !idle && ((state_q == SEQ_CAPTURE) ||
                               ((state_q == SEQ_ARMED) && (cfg_target == '0)));

    always_comb begin
        state_d         = state_q;
        active_target_d = active_target_q;
        stg_g_d         = stg_g_q;
        stg_r_d         = stg_r_q;
        stg_b_d         = stg_b_q;
        captured_d      = captured_q;
        rgb_g_d         = rgb_g_q;
        rgb_r_d         = rgb_r_q;
        rgb_b_d         = rgb_b_q;
        rgb_ready_d     = rgb_ready_q;
        overrun_d       = overrun_q;
        frame_pixels_d  = frame_pixels_q;
        short_frame_d   = 1'b0;

        // The first byte of a frame is handled as if already in its target state.
        if (state_q == SEQ_ARMED) begin
            proc_state = (active_target_q == '0) ? SEQ_CAPTURE : SEQ_SKIP;
        end else begin
            proc_state = state_q;
        end

        if (frame_end) begin
            state_d        = SEQ_ARMED;
            captured_d     = 1'b0;
            frame_pixels_d = pix_idx;
            if (captured_q) begin
                rgb_g_d     = stg_g_q;
                rgb_r_d     = stg_r_q;
                rgb_b_d     = stg_b_q;
                rgb_ready_d = 1'b1;
                overrun_d   = host_clear ? 1'b0 : (overrun_q || rgb_ready_q);
            end else begin
                short_frame_d = 1'b1;
                if (host_clear) begin
                    rgb_ready_d = 1'b0;
                    overrun_d   = 1'b0;
                end
            end
        end else begin
            if (host_clear) begin
                rgb_ready_d = 1'b0;
                overrun_d   = 1'b0;
            end
            // Reload only while staying armed so the frame sees the target it started with.
            if (state_q == SEQ_ARMED && !byte_en) begin
                active_target_d = cfg_target;
            end
            if (byte_en) begin
                state_d = proc_state;
                case (proc_state)
                    SEQ_SKIP: begin
                        if (pixel_done && target_hit) begin
                            state_d = SEQ_CAPTURE;
                        end
                    end
                    SEQ_CAPTURE: begin
                        case (byte_in_pix)
                            SLOT_G:  stg_g_d = byte_data;
                            SLOT_R:  stg_r_d = byte_data;
                            SLOT_B:  stg_b_d = byte_data;
                            default: ;
                        endcase
                        if (pixel_done) begin
                            captured_d = 1'b1;
                            state_d    = SEQ_PASS;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= SEQ_ARMED;
            active_target_q <= cfg_target;
            stg_g_q         <= '0;
            stg_r_q         <= '0;
            stg_b_q         <= '0;
            captured_q      <= 1'b0;
            rgb_g_q         <= '0;
            rgb_r_q         <= '0;
            rgb_b_q         <= '0;
            rgb_ready_q     <= 1'b0;
            overrun_q       <= 1'b0;
            frame_pixels_q  <= '0;
            short_frame_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            active_target_q <= active_target_d;
            stg_g_q         <= stg_g_d;
            stg_r_q         <= stg_r_d;
            stg_b_q         <= stg_b_d;
            captured_q      <= captured_d;
            rgb_g_q         <= rgb_g_d;
            rgb_r_q         <= rgb_r_d;
            rgb_b_q         <= rgb_b_d;
            rgb_ready_q     <= rgb_ready_d;
            overrun_q       <= overrun_d;
            frame_pixels_q  <= frame_pixels_d;
            short_frame_q   <= short_frame_d;
        end
    end

    assign rgb_g        = rgb_g_q;
    assign rgb_r        = rgb_r_q;
    assign rgb_b        = rgb_b_q;
    assign rgb_ready    = rgb_ready_q;
    assign overrun      = overrun_q;
    assign frame_pixels = frame_pixels_q;
    assign short_frame  = short_frame_q;

endmodule

// File: tb/tb_ws2812b_capture_sequencer.sv
// Self-checking bench for ws2812b_capture_sequencer: frame-level scoreboard of
// committed results plus per-byte consume expectations.
module tb_ws2812b_capture_sequencer;

    localparam int PIX_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             idle;
    logic [PIX_W-1:0] cfg_target;
    logic             host_clear;
    logic             consume;
    logic [7:0]       rgb_g, rgb_r, rgb_b;
    logic             rgb_ready;
    logic             overrun;
    logic [PIX_W-1:0] frame_pixels;
    logic             short_frame;

    ws2812b_capture_sequencer #(.PIX_W(PIX_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .idle         (idle),
        .cfg_target   (cfg_target),
        .host_clear   (host_clear),
        .consume      (consume),
        .rgb_g        (rgb_g),
        .rgb_r        (rgb_r),
        .rgb_b        (rgb_b),
        .rgb_ready    (rgb_ready),
        .overrun      (overrun),
        .frame_pixels (frame_pixels),
        .short_frame  (short_frame)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // {g, r, b, ready, overrun, frame_pixels, short_frame}
    logic [34:0] exp_q[$];
    logic [7:0]  frame_q[$];

    logic [7:0] m_g, m_r, m_b;
    logic       m_ready, m_overrun;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input logic exp_cons);
        idle       = 1'b0;
        byte_valid = 1'b0;
        tick();
        check_eq("consume", consume, exp_cons);
        byte_valid = 1'b1;
        byte_data  = d;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic fill_random(input int nbytes);
        frame_q.delete();
        for (int i = 0; i < nbytes; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Model of the frame-end commit, pushed before the frame is driven.
    task automatic predict(input int tgt, input logic hc);
        int   npix;
        logic cap;
        logic [7:0] fp;
        npix = frame_q.size() / 3;
        cap  = (tgt < npix) && (tgt != 255);
        fp   = (npix > 255) ? 8'hFF : 8'(npix);
        if (cap) begin
            m_g       = frame_q[tgt*3];
            m_r       = frame_q[tgt*3+1];
            m_b       = frame_q[tgt*3+2];
            m_overrun = hc ? 1'b0 : (m_overrun | m_ready);
            m_ready   = 1'b1;
        end else if (hc) begin
            m_ready   = 1'b0;
            m_overrun = 1'b0;
        end
        exp_q.push_back({m_g, m_r, m_b, m_ready, m_overrun, fp, !cap});
    endtask

    task automatic end_frame(input logic hc);
        logic [34:0] e;
        idle       = 1'b1;
        byte_valid = 1'b0;
        host_clear = hc;
        tick();
        host_clear = 1'b0;
        check_eq("consume_idle", consume, 1'b0);
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("rgb_g", rgb_g, e[34:27]);
            check_eq("rgb_r", rgb_r, e[26:19]);
            check_eq("rgb_b", rgb_b, e[18:11]);
            check_eq("rgb_ready", rgb_ready, e[10]);
            check_eq("overrun", overrun, e[9]);
            check_eq("frame_pixels", frame_pixels, e[8:1]);
            check_eq("short_frame", short_frame, e[0]);
        end
        idle = 1'b0;
        tick();
        check_eq("short_frame_pulse", short_frame, 1'b0);
    endtask

    task automatic run_frame(input int tgt, input logic hc, input int chg_at, input int new_cfg);
        cfg_target = PIX_W'(tgt);
        predict(tgt, hc);
        for (int k = 0; k < frame_q.size(); k++) begin
            if (k == chg_at) cfg_target = PIX_W'(new_cfg);
            send_byte(frame_q[k], ((k / 3) == tgt) && (tgt != 255));
        end
        end_frame(hc);
    endtask

    task automatic host_ack();
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
        m_ready    = 1'b0;
        m_overrun  = 1'b0;
        check_eq("ack_ready", rgb_ready, 1'b0);
        check_eq("ack_overrun", overrun, 1'b0);
    endtask

    task automatic check_reset_state();
        check_eq("rst_rgb_g", rgb_g, 8'h00);
        check_eq("rst_rgb_r", rgb_r, 8'h00);
        check_eq("rst_rgb_b", rgb_b, 8'h00);
        check_eq("rst_ready", rgb_ready, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_frame_pixels", frame_pixels, 8'h00);
        check_eq("rst_short", short_frame, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        idle       = 1'b0;
        cfg_target = '0;
        host_clear = 1'b0;
        {m_g, m_r, m_b, m_ready, m_overrun} = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_state();
        check_eq("rst_consume_armed", consume, 1'b1);

        // Pixel 0 capture, two pixels in frame.
        frame_q = '{8'h12, 8'h34, 8'h56, 8'h09, 8'h09, 8'h09};
        run_frame(0, 1'b0, -1, 0);

        // Pixel 2 capture in a four-pixel frame; second commit sets overrun.
        fill_random(12);
        frame_q[6] = 8'hAA; frame_q[7] = 8'hBB; frame_q[8] = 8'hCC;
        run_frame(2, 1'b0, -1, 0);
        host_ack();

        // Target beyond frame length: short frame, outputs held.
        fill_random(9);
        run_frame(5, 1'b0, -1, 0);

        // Overrun then commit coinciding with host_clear.
        fill_random(6);  run_frame(1, 1'b0, -1, 0);
        fill_random(9);  run_frame(0, 1'b0, -1, 0);
        fill_random(6);  run_frame(1, 1'b1, -1, 0);

        // Target changes mid-frame: applies to the next frame only.
        fill_random(6);  run_frame(0, 1'b0, 2, 1);
        fill_random(6);  run_frame(1, 1'b0, -1, 0);

        // Reset in the middle of a frame.
        cfg_target = '0;
        fill_random(4);
        for (int k = 0; k < 4; k++) send_byte(frame_q[k], k < 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        {m_g, m_r, m_b, m_ready, m_overrun} = '0;
        check_reset_state();
        check_eq("rst_mid_consume", consume, 1'b1);
        fill_random(6);  run_frame(0, 1'b0, -1, 0);

        // Random frames, including partial trailing pixels.
        for (int i = 0; i < 10; i++) begin
            fill_random($urandom_range(1, 15));
            run_frame($urandom_range(0, 4), 1'($urandom_range(0, 1)), -1, 0);
        end

        check_eq("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
